// File: rtl/fir_decimator_if.sv
// Sample/handshake/status bundle between the FIR decimator and its neighbours.
// The slave modport is the decimator; the master modport is the surrounding logic.
interface fir_decimator_if #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DECIM_W = 8
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [DECIM_W-1:0] decim;
    logic signed [17:0] in;
    logic               valid_in;
    logic signed [17:0] out;
    logic               valid_out;
    logic               ready_in;
    logic [LVL_W-1:0]   level;
    logic               overflow;
    logic               ovf_clr;
    logic [15:0]        drop_cnt;

    modport master (
        output decim, in, valid_in, ready_in, ovf_clr,
        input  out, valid_out, level, overflow, drop_cnt
    );

    modport slave (
        input  decim, in, valid_in, ready_in, ovf_clr,
        output out, valid_out, level, overflow, drop_cnt
    );
endinterface

// File: rtl/fir_decimator.sv
// Keeps one FIR sample in every r, buffers kept samples in a first-word-fall-through
// FIFO and reports level, sticky overflow and a saturating drop count.
module fir_decimator #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DECIM_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    fir_decimator_if.slave bus
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = AW + 1;
    localparam int unsigned DW    = 18;

    logic signed [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    logic [DECIM_W-1:0]   r_phase;
    logic [DECIM_W-1:0]   r_ratio;
    logic signed [DW-1:0] r_out;
    logic                 r_valid_out;
    logic                 r_overflow;
    logic [15:0]          r_drop_cnt;

    logic [DECIM_W-1:0]   w_decim_eff;
    logic [DECIM_W-1:0]   w_ratio;
    logic                 w_wrap;
    logic                 w_keep;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_write;
    logic                 w_drop;
    logic [AW-1:0]        w_rd_ptr_inc;
    logic [LVL_W-1:0]     w_level_next;
    logic signed [DW-1:0] w_head_next;

    // A zero ratio register means "not yet captured since reset": use decim directly.
    assign w_decim_eff  = (bus.decim == '0) ? DECIM_W'(1) : bus.decim;
    assign w_ratio      = (r_ratio == '0) ? w_decim_eff : r_ratio;
    assign w_wrap       = bus.valid_in && (r_phase == (w_ratio - DECIM_W'(1)));
    assign w_keep       = bus.valid_in && (r_phase == '0);

    assign w_full       = (r_level == LVL_W'(DEPTH));
    assign w_pop        = r_valid_out && bus.ready_in;
    assign w_write      = w_keep && (!w_full || w_pop);
    assign w_drop       = w_keep && w_full && !w_pop;
    assign w_rd_ptr_inc = r_rd_ptr + AW'(1);
    assign w_level_next = r_level + LVL_W'(w_write) - LVL_W'(w_pop);

    // Head of FIFO after this edge; bypasses the incoming sample when the FIFO drains to it.
    always_comb begin
        w_head_next = r_out;
        if (w_pop) begin
            if (r_level > LVL_W'(1)) begin
                w_head_next = r_mem[w_rd_ptr_inc];
            end else if (w_write) begin
                w_head_next = bus.in;
            end
        end else if ((r_level == '0) && w_write) begin
            w_head_next = bus.in;
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= bus.in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase     <= '0;
            r_ratio     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_out       <= '0;
            r_valid_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            if ((r_ratio == '0) || w_wrap) begin
                r_ratio <= w_decim_eff;
            end
            if (bus.valid_in) begin
                r_phase <= w_wrap ? '0 : (r_phase + DECIM_W'(1));
            end
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_level     <= w_level_next;
            r_valid_out <= (w_level_next != '0);
            r_out       <= w_head_next;
            // A drop in the same cycle as a clear leaves a fresh count of one.
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (bus.ovf_clr) begin
                    r_drop_cnt <= 16'd1;
                end else if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end else if (bus.ovf_clr) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= '0;
            end
        end
    end

    assign bus.out       = r_out;
    assign bus.valid_out = r_valid_out;
    assign bus.level     = r_level;
    assign bus.overflow  = r_overflow;
    assign bus.drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_fir_decimator.sv
// Randomized and directed bench for fir_decimator with a queue-based reference model
// and a scoreboard monitor that checks every sample popped from the FIFO.
module tb_fir_decimator;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;

    fir_decimator_if #(.DEPTH(DEPTH), .DECIM_W(8)) bus ();

    fir_decimator #(.DEPTH(DEPTH), .DECIM_W(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: frame position, frame ratio, FIFO occupancy, status.
    int exp_q[$];
    int m_level = 0;
    int m_idx   = 0;
    int m_ratio = 0;
    int m_ovf   = 0;
    int m_drop  = 0;

    bit hold_pending = 1'b0;
    int hold_val     = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_ratio(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    // Model: check status against the model, then apply this cycle's inputs.
    always @(negedge clk) begin
        if (!reset) begin
            m_level = 0; m_idx = 0; m_ratio = 0; m_ovf = 0; m_drop = 0;
            exp_q.delete();
        end else begin
            bit pop, keep, wr, drp;
            chk("valid_out", bus.valid_out, (m_level != 0));
            chk("level", bus.level, m_level);
            chk("overflow", bus.overflow, m_ovf);
            chk("drop_cnt", bus.drop_cnt, m_drop);
            if (m_ratio == 0) m_ratio = eff_ratio(int'(bus.decim));
            pop  = (m_level > 0) && bus.ready_in;
            keep = bus.valid_in && (m_idx == 0);
            if (bus.valid_in) begin
                m_idx++;
                if (m_idx == m_ratio) begin
                    m_idx   = 0;
                    m_ratio = eff_ratio(int'(bus.decim));
                end
            end
            wr  = keep && ((m_level < DEPTH) || pop);
            drp = keep && (m_level == DEPTH) && !pop;
            if (wr) exp_q.push_back(int'(bus.in));
            m_level = m_level + int'(wr) - int'(pop);
            if (drp) begin
                m_ovf  = 1;
                m_drop = bus.ovf_clr ? 1 : ((m_drop < 65535) ? m_drop + 1 : 65535);
            end else if (bus.ovf_clr) begin
                m_ovf  = 0;
                m_drop = 0;
            end
        end
    end

    // Scoreboard monitor: every accepted output must be the oldest expected sample.
    always @(negedge clk) begin
        if (reset) begin
            if (hold_pending) chk("out_stable", bus.out, hold_val);
            if (bus.valid_out && bus.ready_in) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL out_data: got %0d, expected no output", bus.out);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("out_data", bus.out, e);
                end
            end
            hold_pending = bus.valid_out && !bus.ready_in;
            hold_val     = int'(bus.out);
        end else begin
            hold_pending = 1'b0;
        end
    end

    task automatic cyc(input bit vld, input int v, input bit rdy, input bit clr);
        @(posedge clk);
        #2;
        bus.valid_in = vld;
        bus.in       = 18'(v);
        bus.ready_in = rdy;
        bus.ovf_clr  = clr;
    endtask

    // Reset pulse asserted between edges; state must clear without a clock edge.
    task automatic do_reset(input int d);
        @(posedge clk);
        #2;
        reset        = 1'b0;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b0;
        bus.ovf_clr  = 1'b0;
        bus.decim    = 8'(d);
        #1;
        chk("rst_level", bus.level, 0);
        chk("rst_valid_out", bus.valid_out, 0);
        chk("rst_out", bus.out, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_drop_cnt", bus.drop_cnt, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        bus.decim = 8'd1; bus.in = '0; bus.valid_in = 1'b0;
        bus.ready_in = 1'b0; bus.ovf_clr = 1'b0;
        repeat (2) @(posedge clk);

        // Ratio 1 pass-through
        do_reset(1);
        for (int i = 1; i <= 4; i++) cyc(1'b1, i, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 0, 1'b1, 1'b0);

        // Ratio 3 with gaps
        do_reset(3);
        for (int i = 0; i <= 8; i++) begin
            cyc(1'b1, i, 1'b1, 1'b0);
            cyc(1'b0, 0, 1'b1, 1'b0);
        end
        repeat (3) cyc(1'b0, 0, 1'b1, 1'b0);

        // Ratio change mid-frame
        do_reset(4);
        cyc(1'b1, 10, 1'b1, 1'b0);
        cyc(1'b1, 11, 1'b1, 1'b0);
        bus.decim = 8'd2;
        for (int i = 12; i <= 21; i++) cyc(1'b1, i, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 0, 1'b1, 1'b0);

        // Fill past full, drain, clear status
        do_reset(1);
        for (int i = -5; i <= 14; i++) cyc(1'b1, i, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_level", bus.level, 16);
        chk("full_overflow", bus.overflow, 1);
        chk("full_drop_cnt", bus.drop_cnt, 4);
        repeat (18) cyc(1'b0, 0, 1'b1, 1'b0);
        chk("drain_empty", exp_q.size(), 0);
        cyc(1'b0, 0, 1'b1, 1'b1);
        cyc(1'b0, 0, 1'b1, 1'b0);
        @(negedge clk);
        chk("clr_overflow", bus.overflow, 0);
        chk("clr_drop_cnt", bus.drop_cnt, 0);

        // Full FIFO with simultaneous pop and write of 100
        for (int i = 0; i < 16; i++) cyc(1'b1, i * 3 - 7, 1'b0, 1'b0);
        cyc(1'b1, 100, 1'b1, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("fullpop_level", bus.level, 16);
        chk("fullpop_overflow", bus.overflow, 0);
        repeat (17) cyc(1'b0, 0, 1'b1, 1'b0);
        chk("fullpop_empty", exp_q.size(), 0);

        // Async reset mid-operation (level 7, phase 2), then first sample kept
        do_reset(3);
        for (int i = 0; i < 20; i++) cyc(1'b1, i, 1'b0, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("mid_level", bus.level, 7);
        do_reset(3);
        cyc(1'b1, -131072, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 0, 1'b1, 1'b0);

        // Randomized traffic with ratio changes, backpressure and clears
        do_reset(int'($urandom_range(0, 4)));
        for (int c = 0; c < 600; c++) begin
            bit vld, rdy, clr;
            int v;
            vld = ($urandom % 4) != 0;
            rdy = (c < 300) ? (($urandom % 5) == 0) : (($urandom % 2) == 0);
            clr = ($urandom % 29) == 0;
            v   = int'($urandom_range(0, 262143)) - 131072;
            if ((c % 37) == 0) bus.decim = 8'($urandom_range(0, 5));
            cyc(vld, v, rdy, clr);
        end
        repeat (40) cyc(1'b0, 0, 1'b1, 1'b0);
        chk("final_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
- Sits directly downstream of the FIR filter.
- Consumes the filter's 18-bit signed sample stream, keeps one sample in every DECIM, and buffers the kept samples in a small FIFO.
- Presents the buffered samples to the next stage (CPU/DMA capture or audio path) with a valid/ready handshake.
- Reports FIFO level, a sticky overflow flag and a saturating drop counter for software.

Parameters:
- DEPTH, 16, FIFO depth in samples; power of two, 4..256.
- DECIM_W, 8, width of the runtime decimation-ratio input.

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-low reset.
- decim  input  DECIM_W  decimation ratio; 0 is treated as 1.
- in  input  18  signed sample from the FIR filter.
- valid_in  input  1  in is valid this cycle.
- out  output  18  signed sample at the FIFO head.
- valid_out  output  1  out holds a valid sample.
- ready_in  input  1  downstream accepts out this cycle.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; a kept sample was dropped because the FIFO was full.
- ovf_clr  input  1  one-cycle pulse clearing overflow and drop_cnt.
- drop_cnt  output  16  saturating count of dropped samples.

Behaviour:
- Reset: reset low asynchronously clears the phase counter, ratio latch, FIFO pointers, level, out, valid_out, overflow and drop_cnt, all to 0.
- Ratio latch: the effective ratio r = max(decim,1) is captured into an internal latch at reset release, and again whenever the phase counter wraps. A change to decim mid-frame takes effect only at the next wrap.
- Phase counter:
  - Counts 0..r-1 and advances only on valid_in=1.
  - When phase==r-1 and valid_in=1, it wraps to 0.
  - A sample is "kept" when valid_in=1 and phase==0, so the first valid sample after reset is always kept.
  - With r=1, every valid sample is kept.
- FIFO write: a kept sample is written if the FIFO is not full. Exception: when the FIFO is full and a read pop occurs in the same cycle, the write also proceeds and level is unchanged.
- FIFO drop: if the FIFO is full and no pop occurs, the kept sample is discarded, overflow is set and drop_cnt increments, saturating at 16'hFFFF.
- ovf_clr: clears overflow and drop_cnt to 0. If a drop occurs in the same cycle, the drop wins: overflow=1 and drop_cnt=1.
- FIFO read: first-word-fall-through.
  - valid_out = (level != 0).
  - A pop happens when valid_out & ready_in; pointers advance and level decrements.
  - While valid_out=1 and ready_in=0, out must hold stable.
- Latency: a sample kept in cycle N into an empty FIFO appears on out with valid_out=1 in cycle N+1. ready_in in cycle N+1 pops it.
- Simultaneous write and pop with 0<level<DEPTH: level is unchanged and data order is preserved.
- Pop on empty: not possible, since valid_out=0. ready_in is ignored when empty.
- Arithmetic: samples pass bit-exact, with no rounding or scaling.
- Pointers: read and write pointers wrap modulo DEPTH. level is derived from a counter of width $clog2(DEPTH)+1 and reaches exactly DEPTH when full.

Test Plan:
- Ratio 1, pass-through: decim=1, ready_in=1, drive in=1,2,3,4 on 4 consecutive valid cycles → out=1,2,3,4 on cycles 1..4 after each input; level never exceeds 1.
- Ratio 3 with gaps: decim=3, valid_in every other cycle, in=0..8 → only 0,3,6 emerge, in order; level peaks at 1.
- Ratio change mid-frame: decim=4, send 2 samples (10,11), set decim=2, send 10 more (12..21) → kept samples 10,14,16,18,20; the new ratio applies only after the wrap at sample 13.
- Full and overflow: DEPTH=16, decim=1, ready_in=0, 20 samples of -5..14 → level=16, overflow=1, drop_cnt=4; releasing ready_in drains -5..10 exactly. An ovf_clr pulse then yields overflow=0, drop_cnt=0.
- Full with simultaneous pop: FIFO full, ready_in=1 during a kept write of value 100 → no drop, level stays 16, and 100 is the last sample drained.
- Async reset mid-operation: level=7 and phase=2, pull reset low between clock edges → level=0 and valid_out=0 immediately. After release, the first valid sample (e.g. -131072) is kept and output unchanged.
